// File: rtl/button_debouncer_pkg.sv
// Shared debounce definitions: filter state encodings and default timing constants,
// reusable by any input-conditioning block.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        RISE_WAIT   = 2'b01,
        HIGH_STABLE = 2'b11,
        FALL_WAIT   = 2'b10
    } deb_state_e;

    // 10 ms / 500 ms at a 50 MHz clock.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_CNT_W           = 20;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchroniser for one asynchronous bit; both flops clear to 0
// on synchronous active-low reset.
module button_debouncer_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchroniser, stability counter and 4-state filter FSM.
// Define DEBOUNCER_HOLD_EN to add the long-press output bt_hold and its counter.
//
// state       | meaning
// LOW_STABLE  | accepted level 0, idle
// RISE_WAIT   | input high, qualifying a 0->1 change
// HIGH_STABLE | accepted level 1 (hold counter runs here)
// FALL_WAIT   | input low, qualifying a 1->0 change
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter bit ACTIVE_LOW_IN   = 1'b0,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic bt_raw,
    output logic bt_out,
    output logic bt_busy
`ifdef DEBOUNCER_HOLD_EN
    ,
    output logic bt_hold
`endif
);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 ||
        (longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("button_debouncer: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_raw_n;
    logic             w_s2;
    deb_state_e       r_state;
    deb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_bt_out;
    logic             r_bt_busy;
    logic             w_out_nxt;
    logic             w_busy_nxt;

    assign w_raw_n = bt_raw ^ ACTIVE_LOW_IN;

    button_debouncer_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_raw_n),
        .o_q   (w_s2)
    );

    // State register; outputs are registered alongside so they never glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= LOW_STABLE;
            r_cnt     <= '0;
            r_bt_out  <= 1'b0;
            r_bt_busy <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bt_out  <= w_out_nxt;
            r_bt_busy <= w_busy_nxt;
        end
    end

    // Counter clears on every state change, so it never reaches past CNT_TC.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            LOW_STABLE: begin
                if (w_s2) w_state_nxt = RISE_WAIT;
            end
            RISE_WAIT: begin
                if (!w_s2)                w_state_nxt = LOW_STABLE;
                else if (r_cnt == CNT_TC) w_state_nxt = HIGH_STABLE;
                else                      w_cnt_nxt   = r_cnt + 1'b1;
            end
            HIGH_STABLE: begin
                if (!w_s2) w_state_nxt = FALL_WAIT;
            end
            FALL_WAIT: begin
                if (w_s2)                 w_state_nxt = HIGH_STABLE;
                else if (r_cnt == CNT_TC) w_state_nxt = LOW_STABLE;
                else                      w_cnt_nxt   = r_cnt + 1'b1;
            end
            default: w_state_nxt = LOW_STABLE;
        endcase
    end

    always_comb begin
        w_out_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            LOW_STABLE:  begin w_out_nxt = 1'b0; w_busy_nxt = 1'b0; end
            RISE_WAIT:   begin w_out_nxt = 1'b0; w_busy_nxt = 1'b1; end
            HIGH_STABLE: begin w_out_nxt = 1'b1; w_busy_nxt = 1'b0; end
            FALL_WAIT:   begin w_out_nxt = 1'b1; w_busy_nxt = 1'b1; end
            default:     begin w_out_nxt = 1'b0; w_busy_nxt = 1'b0; end
        endcase
    end

    assign bt_out  = r_bt_out;
    assign bt_busy = r_bt_busy;

`ifdef DEBOUNCER_HOLD_EN
    localparam int              HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_TC  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_bt_hold;

    // Counts only while staying in HIGH_STABLE; any exit or re-entry restarts at 0.
    always_ff @(posedge clk) begin
        if (!reset || !(r_state == HIGH_STABLE && w_state_nxt == HIGH_STABLE)) begin
            r_hold_cnt <= '0;
            r_bt_hold  <= 1'b0;
        end else begin
            if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;
            if (r_hold_cnt >= HOLD_TC)  r_bt_hold  <= 1'b1;
        end
    end

    assign bt_hold = r_bt_hold;
`endif

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw, bouncy push-button or switch line into a clean, glitch-free level.
- Sits directly upstream of the edge detector. Its `bt_out` drives the edge detector's `bt_in`, so one physical press produces exactly one one-cycle pulse downstream.
- Contains a two-flop synchroniser, a stability counter and a 4-state filter FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a new level (10 ms at 50 MHz); legal range ≥ 2.
- CNT_W, 20, width of the stability counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW_IN, 0, when 1 the raw input is inverted before synchronisation (pull-up buttons).
- HOLD_CYCLES, 25000000, optional-feature only: stable-pressed cycles before `bt_hold` asserts; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
- bt_raw  input  1  asynchronous raw button line.
- bt_out  output  1  debounced level, registered; feeds the edge detector.
- bt_busy  output  1  registered; high while a candidate level change is being qualified.
- bt_hold  output  1  long-press flag; present only with DEBOUNCER_HOLD_EN.

Behaviour:
- Input path: `raw_n = bt_raw ^ ACTIVE_LOW_IN` → `s1` → `s2` (two flops, no logic between them). Only `s2` is used downstream.
- Reset (reset == 0 at a rising edge), everything synchronous:
  - `s1 = s2 = 0`, state = LOW_STABLE, cnt = 0.
  - `bt_out = 0`, `bt_busy = 0`, `bt_hold = 0`.
  - Reset asserted mid-qualification aborts it with no output change other than forcing the reset values.
- FSM states: LOW_STABLE, RISE_WAIT, HIGH_STABLE, FALL_WAIT.
- LOW_STABLE:
  - `s2 == 1` → RISE_WAIT, cnt = 0, `bt_busy = 1`.
  - Otherwise stay, cnt = 0.
- RISE_WAIT:
  - `s2 == 0` → LOW_STABLE, cnt = 0, `bt_busy = 0` (bounce rejected; `bt_out` never moved).
  - Else if `cnt == DEBOUNCE_CYCLES-1` → HIGH_STABLE, `bt_out = 1`, `bt_busy = 0`, cnt = 0.
  - Else cnt = cnt + 1.
- HIGH_STABLE and FALL_WAIT mirror the above with polarities swapped; `bt_out` is cleared on acceptance.
- Latency: if `raw_n` changes before edge 0 and holds, `s2` shows it after edge 1, the FSM enters WAIT at edge 2, and `bt_out` changes at edge DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches `bt_out`.
- Counter never wraps: it clears on every state change and its terminal value is DEBOUNCE_CYCLES-1 < 2^CNT_W.
- The counter and FSM update in the same edge, so no simultaneous-event ambiguity exists.
- `bt_out` is driven only from the FSM register and never toggles twice within DEBOUNCE_CYCLES+1 cycles.
- Illegal or unreachable state encodings return to LOW_STABLE with `bt_out = 0`.

Optional Feature:
- Macro: DEBOUNCER_HOLD_EN.
- Defined:
  - Adds output `bt_hold` and a separate hold counter (width ceil(log2(HOLD_CYCLES+1))).
  - In HIGH_STABLE the hold counter increments and saturates. At HOLD_CYCLES-1, `bt_hold = 1` on the next edge.
  - `bt_hold` clears, and the hold counter zeroes, on the edge the FSM leaves HIGH_STABLE (entering FALL_WAIT).
  - A bounce back to HIGH_STABLE restarts the hold count from 0.
- Undefined: no `bt_hold` port, no hold counter; the remaining behaviour is identical.

Decomposition:
- Shared include `debounce_defs.vh`:
  - 2-bit state encodings LOW_STABLE = 2'b00, RISE_WAIT = 2'b01, HIGH_STABLE = 2'b11, FALL_WAIT = 2'b10.
  - Default DEBOUNCE_CYCLES and HOLD_CYCLES constants, reusable by other input blocks.
- One natural sub-module: `sync_2ff`, a generic two-flop synchroniser with reset to 0, instantiated for `bt_raw`.

Test Plan (bench uses DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 6):
- Reset check: hold reset = 0 for 3 cycles with `bt_raw` = 1 → `bt_out`, `bt_busy`, `bt_hold` = 0; the FSM starts qualifying only after reset releases.
- Clean press: raise `bt_raw` before edge 0 and hold → `bt_busy` = 1 from edge 2; `bt_out` = 1 at edge 6 and not earlier; `bt_busy` = 0 at edge 6.
- Bounce rejection:
  - Stimulus: `bt_raw` pattern 1,1,0,1,1,0 per cycle, then 0 steady.
  - Required: `bt_out` stays 0 throughout; `bt_busy` pulses and returns to 0.
- Release with bounce:
  - Stimulus: from `bt_out` = 1, drop `bt_raw` to 0, one-cycle 1 glitch after 2 cycles, then steady 0.
  - Required: `bt_out` falls exactly 6 edges after the last 0-sample restart, with one single transition.
- Mid-qualification reset: assert reset at edge 4 of a clean press → `bt_out` stays 0 and the FSM is back in LOW_STABLE after that edge.
- Hold (DEBOUNCER_HOLD_EN defined):
  - Stimulus: steady press.
  - Required: `bt_hold` = 1 six edges after `bt_out` rises; cleared on the edge FALL_WAIT is entered after release.
  - With the macro undefined, the same stimulus gives identical `bt_out` timing.
